// File: rtl/quad_nco_if.sv
// quad_nco_if: sample-request, configuration and quadrature-output bundle for quad_nco.
//
// Handshake: there is no ready. Inputs (step_in, cfg_valid_in, sync_in) are single-cycle
// commands sampled on every rising clock edge. valid_out is a one-cycle strobe, and the
// consumer must take i_out/q_out/wrap_out in the same cycle. Between strobes, i_out and
// q_out hold the last sample and wrap_out stays low.
interface quad_nco_if #(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 16
);
  logic                     step_in;
  logic                     cfg_valid_in;
  logic [PHASE_W-1:0]       ftw_in;
  logic [PHASE_W-1:0]       phase_offset_in;
  logic                     sync_in;
  logic signed [AMP_W-1:0]  i_out;
  logic signed [AMP_W-1:0]  q_out;
  logic                     valid_out;
  logic                     wrap_out;

  modport master (
    output step_in, cfg_valid_in, ftw_in, phase_offset_in, sync_in,
    input  i_out, q_out, valid_out, wrap_out
  );

  modport slave (
    input  step_in, cfg_valid_in, ftw_in, phase_offset_in, sync_in,
    output i_out, q_out, valid_out, wrap_out
  );
endinterface

// File: rtl/quad_nco.sv
// quad_nco: quadrature NCO built from a phase accumulator and a quarter-wave sine ROM.
//
// The pipeline has a fixed latency of 3 clocks:
//   phase/wrap latch -> quadrant and address decode -> ROM data -> sign/mirror output.
//
// Optional feature: define QUAD_NCO_DITHER_EN to add a 16-bit Galois LFSR phase dither
// ahead of truncation. The default build uses plain truncation.
module quad_nco #(
  parameter int              PHASE_W     = 32,
  parameter int              LUT_ADDR_W  = 8,
  parameter int              AMP_W       = 16,
  parameter logic [PHASE_W-1:0] FTW_DEFAULT = 32'h1999_999A
) (
  input  logic        clk_in,
  input  logic        rst_in,
  quad_nco_if.slave   nco
);
  localparam int  N       = 1 << LUT_ADDR_W;
  localparam int  TOP_W   = LUT_ADDR_W + 2;
  localparam real PI      = 3.14159265358979323846;
  localparam real AMP_MAX = real'((1 << (AMP_W - 1)) - 1);

  // Quarter-wave ROM. The half-index offset makes LUT[k] and LUT[N-1-k] exact mirrors.
  logic [AMP_W-1:0] lut [N];
  for (genvar g = 0; g < N; g++) begin : g_lut
    localparam real ANG = 2.0 * PI * (real'(g) + 0.5) / real'(4 * N);
    localparam int  VAL = $rtoi(AMP_MAX * $sin(ANG) + 0.5);
    assign lut[g] = AMP_W'(VAL);
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_reg;
  logic [PHASE_W-1:0] offset_reg;

  // A sync restarts from phase zero, so its sample can never carry a wrap.
  logic [PHASE_W-1:0] acc_base;
  logic [PHASE_W-1:0] acc_sum;
  logic               acc_carry;
  logic [PHASE_W-1:0] p_full;
  logic               unused_p;

  assign acc_base               = nco.sync_in ? '0 : acc;
  assign {acc_carry, acc_sum}   = {1'b0, acc_base} + {1'b0, ftw_reg};

`ifdef QUAD_NCO_DITHER_EN
  localparam int DW_RAW = PHASE_W - LUT_ADDR_W - 2;
  localparam int DW     = (DW_RAW > 16) ? 16 : DW_RAW;
  localparam logic [15:0] DMASK = (DW == 0) ? 16'h0000 : (16'hFFFF >> (16 - DW));
  logic [15:0] lfsr;

  // Dither LFSR x^16+x^14+x^13+x^11+1, advancing once per sample request.
  always_ff @(posedge clk_in) begin
    if (rst_in)            lfsr <= 16'hACE1;
    else if (nco.step_in)  lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign p_full = acc_base + offset_reg + PHASE_W'(lfsr & DMASK);
`else
  assign p_full = acc_base + offset_reg;
`endif

  // Only the quadrant and ROM-index bits survive; the rest are truncated.
  assign unused_p = ^p_full;

  // Accumulator and configuration registers. A step on this edge uses the old FTW/offset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc        <= '0;
      ftw_reg    <= FTW_DEFAULT;
      offset_reg <= '0;
    end else begin
      acc <= nco.step_in ? acc_sum : acc_base;
      if (nco.cfg_valid_in) begin
        ftw_reg    <= nco.ftw_in;
        offset_reg <= nco.phase_offset_in;
      end
    end
  end

  // Stage 0: latch the lookup phase (quadrant + index) and the wrap bit.
  logic             v0, w0;
  logic [TOP_W-1:0] ph0;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v0  <= 1'b0;
      w0  <= 1'b0;
      ph0 <= '0;
    end else begin
      v0 <= nco.step_in;
      if (nco.step_in) begin
        w0  <= acc_carry;
        ph0 <= p_full[PHASE_W-1 -: TOP_W];
      end
    end
  end

  // Stage 1: decode the quadrants. Cosine uses quadrant+1; odd quadrants read mirrored.
  logic                  v1, w1, neg_s1, neg_c1;
  logic [LUT_ADDR_W-1:0] addr_s1, addr_c1;
  logic [1:0]            quad_s, quad_c;
  logic [LUT_ADDR_W-1:0] k0;
  assign quad_s = ph0[TOP_W-1 -: 2];
  assign quad_c = quad_s + 2'd1;
  assign k0     = ph0[LUT_ADDR_W-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1      <= 1'b0;
      w1      <= 1'b0;
      neg_s1  <= 1'b0;
      neg_c1  <= 1'b0;
      addr_s1 <= '0;
      addr_c1 <= '0;
    end else begin
      v1      <= v0;
      w1      <= w0;
      neg_s1  <= quad_s[1];
      neg_c1  <= quad_c[1];
      addr_s1 <= quad_s[0] ? ~k0 : k0;
      addr_c1 <= quad_c[0] ? ~k0 : k0;
    end
  end

  // Stage 2: dual ROM read.
  logic             v2, w2, neg_s2, neg_c2;
  logic [AMP_W-1:0] dat_s2, dat_c2;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v2     <= 1'b0;
      w2     <= 1'b0;
      neg_s2 <= 1'b0;
      neg_c2 <= 1'b0;
      dat_s2 <= '0;
      dat_c2 <= '0;
    end else begin
      v2     <= v1;
      w2     <= w1;
      neg_s2 <= neg_s1;
      neg_c2 <= neg_c1;
      dat_s2 <= lut[addr_s1];
      dat_c2 <= lut[addr_c1];
    end
  end

  // Stage 3: apply the sign and register the outputs. Samples hold between strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      nco.i_out     <= '0;
      nco.q_out     <= '0;
      nco.valid_out <= 1'b0;
      nco.wrap_out  <= 1'b0;
    end else begin
      nco.valid_out <= v2;
      nco.wrap_out  <= v2 & w2;
      if (v2) begin
        nco.i_out <= neg_c2 ? -dat_c2 : dat_c2;
        nco.q_out <= neg_s2 ? -dat_s2 : dat_s2;
      end
    end
  end
endmodule

// File: tb/tb_quad_nco.sv
// tb_quad_nco: randomized and directed bench for quad_nco (default parameters, no dither).
module tb_quad_nco;
  localparam real PI = 3.14159265358979323846;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  quad_nco_if #(.PHASE_W(32), .AMP_W(16)) nco();

  quad_nco dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .nco    (nco)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- reference state and scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] acc_m, ftw_m, off_m;
  int          last_i  = 0;
  int          last_q  = 0;
  // Entry layout: [64:33] due cycle, [32:17] I, [16:1] Q, [0] wrap.
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ideal sinusoid sampled at the 10-bit truncated phase (bin centre), rounded half away from zero.
  function automatic int ref_wave(input logic [31:0] ph, input bit cosine);
    int  m;
    real s;
    m = int'(ph >> 22);
    if (cosine) m = (m + 256) % 1024;
    s = 32767.0 * $sin(2.0 * PI * (real'(m) + 0.5) / 1024.0);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit st, input bit cfg, input logic [31:0] f,
                       input logic [31:0] o, input bit sy);
    logic [31:0] base, ph;
    logic [32:0] sum;
    int          ie, qe;
    nco.step_in         = st;
    nco.cfg_valid_in    = cfg;
    nco.ftw_in          = f;
    nco.phase_offset_in = o;
    nco.sync_in         = sy;
    @(posedge clk_in);
    cyc++;
    base = sy ? 32'h0 : acc_m;
    sum  = {1'b0, base} + {1'b0, ftw_m};
    if (st) begin
      ph = base + off_m;
      ie = ref_wave(ph, 1'b1);
      qe = ref_wave(ph, 1'b0);
      exp_q.push_back({32'(cyc + 3), 16'(ie), 16'(qe), sum[32]});
      acc_m = sum[31:0];
    end else begin
      acc_m = base;
    end
    if (cfg) begin
      ftw_m = f;
      off_m = o;
    end
    #1;
    nco.step_in      = 1'b0;
    nco.cfg_valid_in = 1'b0;
    nco.sync_in      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    exp_q.delete();
    idle(2);
    rst_in = 1'b0;
    acc_m  = 32'h0;
    ftw_m  = 32'h1999_999A;
    off_m  = 32'h0;
    last_i = 0;
    last_q = 0;
    check("rst_i",     int'(nco.i_out),     0);
    check("rst_q",     int'(nco.q_out),     0);
    check("rst_valid", int'(nco.valid_out), 0);
    check("rst_wrap",  int'(nco.wrap_out),  0);
  endtask

  // ---------------- monitor: compares outputs against the expected queue ----------------
  logic [64:0] mon_e;
  bit          mon_due;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      mon_due = (exp_q.size() > 0) && (int'(exp_q[0][64:33]) == cyc);
      check("valid", int'(nco.valid_out), int'(mon_due));
      if (mon_due) begin
        mon_e = exp_q.pop_front();
        check("i",    int'(nco.i_out),    int'($signed(mon_e[32:17])));
        check("q",    int'(nco.q_out),    int'($signed(mon_e[16:1])));
        check("wrap", int'(nco.wrap_out), int'(mon_e[0]));
        last_i = int'($signed(mon_e[32:17]));
        last_q = int'($signed(mon_e[16:1]));
      end else begin
        check("wrap_idle", int'(nco.wrap_out), 0);
        check("i_hold",    int'(nco.i_out),    last_i);
        check("q_hold",    int'(nco.q_out),    last_q);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nco.step_in = 0; nco.cfg_valid_in = 0; nco.sync_in = 0;
    nco.ftw_in = '0; nco.phase_offset_in = '0;
    acc_m = 0; ftw_m = 32'h1999_999A; off_m = 0;

    do_reset();

    // Default tuning word from reset.
    for (int i = 0; i < 6; i++) drive(1, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Quarter steps: (32767,101) (-101,32767) (-32767,-101) (101,-32767), wrap on the 4th.
    do_reset();
    drive(0, 1, 32'h4000_0000, 32'h0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Offset of 90 degrees with FTW 0, continuous steps.
    drive(0, 1, 32'h0, 32'h4000_0000, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Config/step collision: the sample on that edge still uses the old FTW.
    do_reset();
    drive(0, 1, 32'h4000_0000, 32'h0, 0);
    drive(1, 1, 32'h8000_0000, 32'h0, 0);
    drive(1, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Sync while acc = C000_0000, then a following sample.
    do_reset();
    drive(0, 1, 32'h4000_0000, 32'h0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 32'h0, 32'h0, 1);
    drive(1, 0, 32'h0, 32'h0, 0);
    idle(2);
    drive(0, 0, 32'h0, 32'h0, 1);   // sync alone: restart without a sample
    drive(1, 1, 32'h2000_0000, 32'h1000_0000, 1);  // sync + cfg together
    drive(1, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Reset one cycle after a step: the in-flight sample must vanish.
    drive(1, 0, 32'h0, 32'h0, 0);
    do_reset();
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] f, o;
      f = (($urandom_range(0, 3)) == 0) ? ($urandom_range(0, 3) << 30) : $urandom();
      o = (($urandom_range(0, 3)) == 0) ? 32'h0 : $urandom();
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, f, o,
            $urandom_range(0, 99) < 4);
    end
    idle(6);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_nco.md
# quad_nco

Parametrised quadrature numerically controlled oscillator: a runtime-tunable phase accumulator feeding a quarter-wave sine ROM that produces simultaneous signed cosine (I) and sine (Q) samples. It replaces fixed-frequency, fixed-phase, single-output sine generation in the modulator datapath. The QAM mixer and symbol timing consume it directly, using `wrap_out` as a carrier-cycle marker.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- `PHASE_W`, 32: accumulator, tuning-word and offset width.
- `LUT_ADDR_W`, 8: quarter-wave ROM address width, giving 2^LUT_ADDR_W entries. Legal range 4..12; `LUT_ADDR_W+2 <= PHASE_W`.
- `AMP_W`, 16: output sample width. Legal range 8..24.
- `FTW_DEFAULT`, `32'h1999_999A`: tuning word loaded at reset (10 MHz at a 100 MHz step rate).

**Ports**
- `clk_in`, in, 1: clock.
- `rst_in`, in, 1: synchronous active-high reset.
- `step_in`, in, 1: take one sample and advance the phase.
- `cfg_valid_in`, in, 1: load `ftw_in` and `phase_offset_in`.
- `ftw_in`, in, PHASE_W: frequency tuning word.
- `phase_offset_in`, in, PHASE_W: phase offset; full scale is 360°.
- `sync_in`, in, 1: zero the accumulator (phase-coherent restart).
- `i_out`, out, AMP_W, signed: cosine sample.
- `q_out`, out, AMP_W, signed: sine sample.
- `valid_out`, out, 1: one-cycle strobe marking a new sample.
- `wrap_out`, out, 1: this sample's phase increment overflowed the accumulator.

## Operation

**ROM**
- Quarter-wave, generated at elaboration.
- `LUT[k] = round((2^(AMP_W-1)-1) * sin(2π(k+0.5)/2^(LUT_ADDR_W+2)))`.
- The half-LSB offset gives exact mirror symmetry. The maximum entry is `2^(AMP_W-1)-1`, so negation never overflows.

**Phase slicing and lookup**
- Lookup phase `p = acc + offset_reg`, modulo 2^PHASE_W.
- Quadrant = top 2 bits of `p`; `k` = next LUT_ADDR_W bits; lower bits are truncated.
- Sine by quadrant: 0 → `+LUT[k]`; 1 → `+LUT[N-1-k]`; 2 → `-LUT[k]`; 3 → `-LUT[N-1-k]`.
- Cosine uses the same rule with quadrant+1, modulo 4.
- Both reads occur in the same cycle, using a dual-read ROM or two ROM copies.

**Accumulator**
- On `step_in`, the sample uses the current `acc`, then `acc <= acc + ftw_reg`.
- The carry out of that addition travels with the sample as `wrap_out`.
- `cfg_valid_in` registers `ftw_in` and `phase_offset_in`. The new values first affect a `step_in` on a later edge.
- When `sync_in` is high, the sample taken on that edge uses `acc = 0`. `acc` then becomes `ftw_reg` if `step_in` is high, else 0. `wrap_out` for that sample is 0.

**Edge cases and reset**
- `step_in` low: accumulator holds and no sample is issued. `i_out`/`q_out` hold their last values.
- `step_in` may be high every cycle, giving full throughput.
- Reset state:
  - `acc = 0`, `ftw_reg = FTW_DEFAULT`, `offset_reg = 0`.
  - `i_out = 0`, `q_out = 0`, `valid_out = 0`, `wrap_out = 0`.
  - All pipeline valid bits are cleared.
- Reset asserted mid-operation discards in-flight samples; no `valid_out` emerges from them.

## Timing

- Fixed latency of 3 clocks. A `step_in` sampled at edge n produces `valid_out` high for the single cycle after edge n+3.
- Pipeline stages:
  - Edge n: latch `p` and the wrap bit.
  - Edge n+1: decode quadrant and ROM addresses.
  - Edge n+2: ROM data.
  - Edge n+3: sign and mirror, register outputs.
- `wrap_out` is asserted only together with `valid_out`.
- `cfg_valid_in` and `step_in` on the same edge: the sample uses the old FTW and offset.
- `sync_in` and `cfg_valid_in` on the same edge: both take effect as specified, independently.

## Configuration

`QUAD_NCO_DITHER_EN`
- **Defined:**
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1) is added. It resets to `16'hACE1` and advances once per `step_in`.
  - Its low `min(16, PHASE_W-LUT_ADDR_W-2)` bits are added to `p` before truncation. This spreads truncation spurs.
  - Latency is unchanged.
- **Undefined:**
  - No LFSR; plain truncation.
  - Outputs are fully deterministic, as in all test values below.

## Test plan

All scenarios use default parameters, dither disabled, and N=256, which gives `LUT[0]=101` and `LUT[255]=32767`.

- **Reset values:** after reset, `i_out = 0`, `q_out = 0`, `valid_out = 0`, `wrap_out = 0`.
- **Quarter steps:** load FTW `32'h4000_0000` with offset 0, then pulse `step_in` for 4 cycles. Expected (I,Q):
  - (32767,101)
  - (-101,32767)
  - (-32767,-101)
  - (101,-32767)
  - `wrap_out` is high only on the 4th sample. Each `valid_out` comes exactly 3 cycles after its `step_in`.
- **Offset:** offset `32'h4000_0000` with FTW 0; continuous `step_in`. Every sample is (-101,32767) and `wrap_out` never asserts.
- **Config/step collision:** `cfg_valid_in` with FTW `32'h8000_0000` on the same edge as `step_in`, starting from `acc = 0` and FTW `32'h4000_0000`.
  - 1st sample: (32767,101), taken at phase 0; `acc` advances to `32'h4000_0000` with the old FTW.
  - Next sample: (-101,32767).
  - Third sample: (101,-32767), taken at phase `32'hC000_0000`, proving the new FTW applies.
- **Sync:** `sync_in` with `step_in` while `acc = 32'hC000_0000`. The sample is (32767,101) with `wrap_out` 0, and the following sample reflects `acc = ftw_reg`.
- **Reset mid-flight:** reset asserted one cycle after a `step_in`. No `valid_out` follows, and the outputs read 0.
